// File: rtl/riscv_test_mon_pkg.sv
// Shared types and constants for the end-of-test monitor.
package riscv_test_mon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_PASS = 3'd2,
        ST_FAIL = 3'd3,
        ST_TMO  = 3'd4
    } mon_state_e;

    localparam logic [4:0]  REG_TESTNUM = 5'd3;
    localparam logic [4:0]  REG_END     = 5'd26;
    localparam logic [4:0]  REG_RESULT  = 5'd27;
    localparam int unsigned END_VALUE   = 1;
    localparam int unsigned PASS_VALUE  = 1;

    // Terminal states hold until reset.
    function automatic logic is_terminal(input mon_state_e s);
        return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TMO);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and freeze.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    input  logic         freeze,
    output logic [W-1:0] cnt
);

    // Clear wins, then freeze; counting stops at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (!freeze && inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/riscv_test_monitor.sv
// End-of-test monitor snooping register-file write-back.
// Optional hang detection: define TEST_MON_HANG_DETECT_EN.
module riscv_test_monitor
    import riscv_test_mon_pkg::*;
#(
    parameter int unsigned XLEN           = 64,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned HANG_LIMIT     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wb_en,
    input  logic [4:0]       wb_addr,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             retire_valid,
    input  logic [XLEN-1:0]  retire_pc,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [XLEN-1:0]  fail_testnum,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    mon_state_e      state;
    logic [XLEN-1:0] sh_x3;
    logic [XLEN-1:0] sh_x26;
    logic [XLEN-1:0] sh_x27;

    logic in_run;
    logic in_term;
    logic end_hit;
    logic tmo_hit;
    logic hang_hit;

    // Event decode for the current cycle.
    always_comb begin
        in_run  = (state == ST_RUN);
        in_term = is_terminal(state);
        end_hit = in_run && wb_en && (wb_addr == REG_END)
                  && (wb_data == XLEN'(END_VALUE));
        tmo_hit = in_run && (cycle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    // Shadow copies of x3/x26/x27, tracked in IDLE and RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_x3  <= '0;
            sh_x26 <= '0;
            sh_x27 <= '0;
        end else if (!in_term && wb_en) begin
            if (wb_addr == REG_TESTNUM) sh_x3  <= wb_data;
            if (wb_addr == REG_END)     sh_x26 <= wb_data;
            if (wb_addr == REG_RESULT)  sh_x27 <= wb_data;
        end
    end

    // Cycle counter stops on the timeout value so it holds TIMEOUT_CYCLES-1.
    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (in_run && !tmo_hit),
        .clr    (1'b0),
        .freeze (in_term),
        .cnt    (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_instret_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc    (in_run && retire_valid),
        .clr    (1'b0),
        .freeze (in_term),
        .cnt    (instret_cnt)
    );

`ifdef TEST_MON_HANG_DETECT_EN
    localparam int unsigned HANG_W = $clog2(HANG_LIMIT + 1);

    logic [XLEN-1:0]   last_pc;
    logic [HANG_W-1:0] same_pc;
    logic              pc_same;
    logic              pc_diff;
    logic              unused_bits;

    always_comb begin
        pc_same  = in_run && retire_valid && (retire_pc == last_pc);
        pc_diff  = in_run && retire_valid && (retire_pc != last_pc);
        hang_hit = in_run && (same_pc >= HANG_W'(HANG_LIMIT));
    end

    // Last retired PC, reloaded whenever the PC changes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_pc <= '0;
        end else if (pc_diff) begin
            last_pc <= retire_pc;
        end
    end

    sat_counter #(.W(HANG_W)) u_same_pc (
        .clk    (clk),
        .rst    (rst),
        .inc    (pc_same),
        .clr    (pc_diff),
        .freeze (!in_run),
        .cnt    (same_pc)
    );

    assign unused_bits = ^sh_x26;
`else
    logic unused_bits;

    assign hang_hit    = 1'b0;
    assign unused_bits = ^{sh_x26, retire_pc, 32'(HANG_LIMIT)};
`endif

    // Verdict FSM with registered status; verdict > hang > cycle timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail         <= 1'b0;
            timeout      <= 1'b0;
            fail_testnum <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (end_hit) begin
                        done         <= 1'b1;
                        fail_testnum <= sh_x3;
                        if (sh_x27 == XLEN'(PASS_VALUE)) begin
                            state <= ST_PASS;
                            pass  <= 1'b1;
                        end else begin
                            state <= ST_FAIL;
                            fail  <= 1'b1;
                        end
                    end else if (hang_hit || tmo_hit) begin
                        state        <= ST_TMO;
                        done         <= 1'b1;
                        timeout      <= 1'b1;
                        fail_testnum <= sh_x3;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed self-checking bench for riscv_test_monitor.
module tb_riscv_test_monitor;

    logic        clk;
    logic        rst;
    logic        en;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic        retire_valid;
    logic [63:0] retire_pc;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [63:0] fail_testnum;
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;

    int n_checks = 0;
    int n_errors = 0;

    riscv_test_monitor #(
        .XLEN           (64),
        .CNT_W          (32),
        .TIMEOUT_CYCLES (50),
        .HANG_LIMIT     (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .retire_valid (retire_valid),
        .retire_pc    (retire_pc),
        .done         (done),
        .pass         (pass),
        .fail         (fail),
        .timeout      (timeout),
        .fail_testnum (fail_testnum),
        .cycle_cnt    (cycle_cnt),
        .instret_cnt  (instret_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] addr, input logic [63:0] data);
        wb_en   = 1'b1;
        wb_addr = addr;
        wb_data = data;
        tick();
        wb_en   = 1'b0;
        wb_addr = 5'd0;
        wb_data = 64'd0;
    endtask

    task automatic apply_reset();
        rst          = 1'b0;
        en           = 1'b0;
        wb_en        = 1'b0;
        wb_addr      = 5'd0;
        wb_data      = 64'd0;
        retire_valid = 1'b0;
        retire_pc    = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic start_run();
        en = 1'b1;
        tick();
        en = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        apply_reset();

        // Reset state
        check("rst_done",    64'(done), 64'd0);
        check("rst_pass",    64'(pass), 64'd0);
        check("rst_fail",    64'(fail), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        check("rst_testnum", fail_testnum, 64'd0);
        check("rst_cycles",  64'(cycle_cnt), 64'd0);
        check("rst_instret", 64'(instret_cnt), 64'd0);

        // Pass sequence: two retirements, then x26=1 with x27=1
        start_run();
        retire_valid = 1'b1;
        retire_pc    = 64'h100;
        wb(5'd3, 64'd5);
        retire_pc    = 64'h104;
        wb(5'd27, 64'd1);
        retire_valid = 1'b0;
        wb(5'd26, 64'd1);
        check("pass_done",    64'(done), 64'd1);
        check("pass_pass",    64'(pass), 64'd1);
        check("pass_fail",    64'(fail), 64'd0);
        check("pass_timeout", 64'(timeout), 64'd0);
        check("pass_testnum", fail_testnum, 64'd5);
        check("pass_cycles",  64'(cycle_cnt), 64'd3);
        check("pass_instret", 64'(instret_cnt), 64'd2);
        retire_valid = 1'b1;
        retire_pc    = 64'h108;
        repeat (3) tick();
        retire_valid = 1'b0;
        check("pass_cycles_frozen",  64'(cycle_cnt), 64'd3);
        check("pass_instret_frozen", 64'(instret_cnt), 64'd2);
        check("pass_sticky",         64'(pass), 64'd1);

        // Asynchronous reset from PASS, mid-cycle
        #2;
        rst = 1'b0;
        #1;
        check("arst_done",    64'(done), 64'd0);
        check("arst_pass",    64'(pass), 64'd0);
        check("arst_testnum", fail_testnum, 64'd0);
        check("arst_cycles",  64'(cycle_cnt), 64'd0);
        check("arst_instret", 64'(instret_cnt), 64'd0);
        rst = 1'b1;

        // IDLE ignores the verdict write but tracks x27
        wb(5'd27, 64'd1);
        wb(5'd26, 64'd1);
        tick();
        check("idle_no_verdict", 64'(done), 64'd0);
        check("idle_cycles",     64'(cycle_cnt), 64'd0);
        start_run();
        check("run_entry_cycles", 64'(cycle_cnt), 64'd0);
        wb(5'd26, 64'd1);
        check("late_en_pass",    64'(pass), 64'd1);
        check("late_en_testnum", fail_testnum, 64'd0);

        // Fail sequence
        apply_reset();
        start_run();
        wb(5'd3, 64'd12);
        wb(5'd27, 64'd0);
        wb(5'd26, 64'd1);
        check("fail_done",    64'(done), 64'd1);
        check("fail_fail",    64'(fail), 64'd1);
        check("fail_pass",    64'(pass), 64'd0);
        check("fail_timeout", 64'(timeout), 64'd0);
        check("fail_testnum", fail_testnum, 64'd12);

        // x0 writes and x26=2 give no verdict
        apply_reset();
        start_run();
        wb(5'd27, 64'd1);
        wb(5'd0, 64'd1);
        wb(5'd26, 64'd2);
        tick();
        check("ignored_done", 64'(done), 64'd0);
        check("ignored_pass", 64'(pass), 64'd0);
        wb(5'd26, 64'd1);
        check("after_ignored_pass", 64'(pass), 64'd1);

        // Timeout after the 50th RUN cycle
        apply_reset();
        wb(5'd3, 64'd7);
        start_run();
        repeat (49) tick();
        check("pre_tmo_timeout", 64'(timeout), 64'd0);
        check("pre_tmo_cycles",  64'(cycle_cnt), 64'd49);
        tick();
        check("tmo_timeout", 64'(timeout), 64'd1);
        check("tmo_done",    64'(done), 64'd1);
        check("tmo_pass",    64'(pass), 64'd0);
        check("tmo_testnum", fail_testnum, 64'd7);
        check("tmo_cycles",  64'(cycle_cnt), 64'd49);
        repeat (3) tick();
        check("tmo_cycles_held", 64'(cycle_cnt), 64'd49);

        // Verdict write on the expiry cycle wins
        apply_reset();
        start_run();
        wb(5'd27, 64'd1);
        repeat (48) tick();
        check("tie_pre_cycles",  64'(cycle_cnt), 64'd49);
        check("tie_pre_timeout", 64'(timeout), 64'd0);
        wb(5'd26, 64'd1);
        check("tie_pass",    64'(pass), 64'd1);
        check("tie_timeout", 64'(timeout), 64'd0);
        check("tie_cycles",  64'(cycle_cnt), 64'd49);

`ifdef TEST_MON_HANG_DETECT_EN
        // Alternating PCs never hang; five same-PC retirements do
        apply_reset();
        start_run();
        retire_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            retire_pc = (i % 2 == 0) ? 64'h80000000 : 64'h80000004;
            tick();
        end
        check("alt_pc_timeout", 64'(timeout), 64'd0);
        retire_pc = 64'h80000040;
        repeat (5) tick();
        retire_valid = 1'b0;
        check("hang_pre_timeout", 64'(timeout), 64'd0);
        tick();
        check("hang_timeout", 64'(timeout), 64'd1);
        check("hang_done",    64'(done), 64'd1);
        check("hang_instret", 64'(instret_cnt), 64'd15);
`else
        // Without hang detection repeated PCs are just counted
        apply_reset();
        start_run();
        retire_valid = 1'b1;
        retire_pc    = 64'h80000040;
        repeat (6) tick();
        retire_valid = 1'b0;
        tick();
        check("same_pc_no_timeout", 64'(timeout), 64'd0);
        check("same_pc_instret",    64'(instret_cnt), 64'd6);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/riscv_test_monitor.md
Name: riscv_test_monitor

Overview:
Synthesizable end-of-test monitor that sits directly downstream of the core's register-file write-back port. It snoops write-back traffic and keeps shadow copies of x3 (test number), x26 (test-end flag) and x27 (pass flag). It raises sticky done, pass, fail and timeout status, and counts cycles and retired instructions. It replaces the per-cycle hierarchical peeking done by the simulation top, so the same verdict is available in simulation, emulation and FPGA builds.

Parameters:
XLEN, 64, data width of the write-back bus and the shadow registers
CNT_W, 32, width of the cycle and instret counters (saturating)
TIMEOUT_CYCLES, 100000, number of RUN cycles before the TIMEOUT verdict
HANG_LIMIT, 16, consecutive same-PC retirements that count as a hang (only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
en  in  1  start monitoring; sampled only in IDLE
wb_en  in  1  register-file write enable
wb_addr  in  5  register-file write index
wb_data  in  XLEN  register-file write data
retire_valid  in  1  one instruction retired this cycle
retire_pc  in  XLEN  PC of the retiring instruction
done  out  1  verdict reached (sticky)
pass  out  1  test passed (sticky)
fail  out  1  test failed (sticky)
timeout  out  1  timeout or hang (sticky)
fail_testnum  out  XLEN  x3 shadow captured at the verdict
cycle_cnt  out  CNT_W  RUN cycles elapsed
instret_cnt  out  CNT_W  instructions retired in RUN

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0; shadows x3, x26 and x27 are 0; counters are 0.
- States: IDLE, RUN, PASS, FAIL, TMO.
  - IDLE -> RUN on the first clk edge with en=1.
  - PASS, FAIL and TMO are terminal; only reset leaves them.
- Shadow update happens in every state except the terminal states:
  - wb_en=1 and wb_addr in {3, 26, 27} loads the matching shadow with wb_data.
  - wb_addr=0 is ignored.
  - Writes are tracked in IDLE as well, so a late en still sees prior setup.
- Verdict is taken in RUN only, on a write with wb_en=1, wb_addr=26 and wb_data=1:
  - Shadow x27==1 gives PASS; any other value gives FAIL.
  - The verdict uses the x27 shadow value before this edge. There is a single write port, so there is no same-cycle x27 hazard.
  - A write of any value other than 1 to x26 only updates the shadow.
- Latency: the status outputs and fail_testnum are registered and assert on the edge that samples the x26 write, visible in the next cycle.
  - fail_testnum is the x3 shadow at that edge; it is also loaded on PASS and TMO.
- Status flags:
  - done=1 in PASS, FAIL and TMO.
  - pass=1 only in PASS; fail=1 only in FAIL; timeout=1 only in TMO.
  - The flags are mutually exclusive, except that done accompanies each of them.
- cycle_cnt:
  - Increments every RUN cycle.
  - Reaching TIMEOUT_CYCLES-1 while in RUN moves to TMO.
  - Saturates at all-ones; it never wraps.
  - Freezes in terminal states.
- instret_cnt increments on retire_valid in RUN, saturates at all-ones, and freezes in terminal states.
- Simultaneous events: an x26==1 write in the same cycle as timeout expiry resolves to PASS/FAIL, not TMO.
- Reset asserted mid-RUN or in a terminal state returns to IDLE immediately and clears everything.

Optional Feature:
- Macro: TEST_MON_HANG_DETECT_EN.
- When defined:
  - Tracks last_pc and a same_pc counter.
  - Each retire_valid in RUN with retire_pc==last_pc increments same_pc; a different PC resets same_pc to 0 and loads last_pc.
  - same_pc reaching HANG_LIMIT moves to TMO in the next cycle.
  - Priority: x26 verdict > hang > cycle timeout.
- When undefined: no hang logic and no extra flops; HANG_LIMIT is unused; TMO is reached only through the cycle timeout.

Decomposition:
- Package riscv_test_mon_pkg holds:
  - the state enum (IDLE, RUN, PASS, FAIL, TMO);
  - the constants REG_TESTNUM=3, REG_END=26, REG_RESULT=27, END_VALUE=1, PASS_VALUE=1.
- One natural sub-module: sat_counter, parameterised by width, with inc, clr and freeze inputs and saturation at all-ones.
  - Instantiated twice: cycle_cnt and instret_cnt.
  - Instantiated a third time for same_pc when TEST_MON_HANG_DETECT_EN is defined.

Test Plan:
1. Pass sequence:
   - Stimulus: en=1; write x3=5; write x27=1; write x26=1.
   - Required: the next cycle shows done=1, pass=1, fail=0, fail_testnum=5, and the counters then freeze.
2. Fail sequence:
   - Stimulus: write x3=12; write x27=0; write x26=1.
   - Required: done=1, fail=1, fail_testnum=12, pass=0.
3. Timeout:
   - Stimulus: TIMEOUT_CYCLES=50, en=1, no x26 write.
   - Required: timeout=1 and done=1 after the 50th RUN cycle; cycle_cnt=49 and held.
4. Tie and ignored writes:
   - Stimulus: the x26=1 write (with x27=1) lands on the timeout-expiry cycle.
   - Required: pass=1, timeout=0.
   - Additionally, x0 writes and an x26=2 write produce no verdict.
5. Reset mid-run:
   - Stimulus: pull rst low after PASS.
   - Required: all outputs read 0 immediately, without waiting for clk; after release the block is in IDLE until en=1.
6. Hang (TEST_MON_HANG_DETECT_EN defined, HANG_LIMIT=4):
   - Stimulus: retire PC 0x80000040 five times in a row.
   - Required: timeout=1.
   - With alternating PCs, no timeout occurs.
